// File: rtl/sync_fifo3_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package sync_fifo3_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned cnt_width(input int unsigned asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/fifomem3.sv
// DSIZE x DEPTH register-array storage: synchronous write port, combinational read port.
module fifomem3 #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo3.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo3
  import sync_fifo3_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned FWFT      = FIFO_STD,
  parameter int unsigned AFULL_TH  = 2 ** ASIZE - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DSIZE-1:0]              wdata,
  input  logic                          winc,
  input  logic                          rinc,
  input  logic                          clr_err,
  output logic [DSIZE-1:0]              rdata,
  output logic                          wfull,
  output logic                          rempty,
  output logic                          afull,
  output logic                          aempty,
  output logic [cnt_width(ASIZE)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned DEPTH = 2 ** ASIZE;
  localparam int unsigned CW    = cnt_width(ASIZE);

  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] AfullC  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_TH);

  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok, rd_ok;
  logic [DSIZE-1:0] mem_rdata;

  // Flags decode only the registered count, so they never glitch within a cycle.
  assign wfull  = (count_q == DepthC);
  assign rempty = (count_q == '0);
  assign afull  = (count_q >= AfullC);
  assign aempty = (count_q <= AemptyC);

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q & ~clr_err) | (winc & wfull);
    underflow_d = (underflow_q & ~clr_err) | (rinc & rempty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifomem3 #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rd_ok) begin
        rdata_q <= mem_rdata;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo3.sv
// Directed bench for sync_fifo3: standard-mode instance plus an FWFT instance.
module tb_sync_fifo3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       winc0 = 1'b0, rinc0 = 1'b0, clr0 = 1'b0;
  logic       winc1 = 1'b0, rinc1 = 1'b0, clr1 = 1'b0;
  logic [7:0] rdata0, rdata1;
  logic       wfull0, rempty0, afull0, aempty0, ovf0, udf0;
  logic       wfull1, rempty1, afull1, aempty1, ovf1, udf1;
  logic [4:0] count0, count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo3 #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wdata(wdata0), .winc(winc0), .rinc(rinc0), .clr_err(clr0),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .afull(afull0), .aempty(aempty0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo3 #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(wdata1), .winc(winc1), .rinc(rinc1), .clr_err(clr1),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .afull(afull1), .aempty(aempty1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  int         nw, nr, occ, cyc;
  bit         w, r;

  initial begin
    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rempty", rempty0, 1);
    chk("rst_aempty", aempty0, 1);
    chk("rst_count", count0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_wfull", wfull0, 0);
    chk("rst_afull", afull0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);

    // Basic order, one-cycle read latency
    winc0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wdata0 = 8'(i);
      tick();
    end
    winc0 = 1'b0;
    chk("basic_count3", count0, 3);
    chk("basic_aempty3", aempty0, 0);
    rinc0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("basic_rdata", rdata0, i);
    end
    rinc0 = 1'b0;
    chk("basic_rempty", rempty0, 1);

    // Fill, full, overflow
    winc0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata0 = 8'(i);
      tick();
      chk("fill_count", count0, i + 1);
      chk("fill_afull", afull0, (i + 1 >= 14));
    end
    chk("fill_wfull", wfull0, 1);
    wdata0 = 8'hEE;
    tick();
    winc0 = 1'b0;
    chk("ovf_set", ovf0, 1);
    chk("ovf_count", count0, 16);
    rinc0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_rdata", rdata0, i);
    end
    rinc0 = 1'b0;
    chk("drain_rempty", rempty0, 1);
    chk("drain_udf", udf0, 0);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("ovf_clr", ovf0, 0);

    // Simultaneous winc+rinc when full
    winc0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata0 = 8'h20 + 8'(i);
      tick();
    end
    wdata0 = 8'h77;
    rinc0  = 1'b1;
    tick();
    winc0 = 1'b0;
    chk("full_both_count", count0, 15);
    chk("full_both_ovf", ovf0, 1);
    chk("full_both_rdata", rdata0, 8'h20);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("full_both_drain", rdata0, 8'h20 + i);
    end
    rinc0 = 1'b0;
    chk("full_both_empty", rempty0, 1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;

    // Simultaneous winc+rinc when empty
    winc0  = 1'b1;
    rinc0  = 1'b1;
    wdata0 = 8'h55;
    tick();
    winc0 = 1'b0;
    chk("empty_both_count", count0, 1);
    chk("empty_both_udf", udf0, 1);
    chk("empty_both_rempty", rempty0, 0);
    tick();
    rinc0 = 1'b0;
    chk("empty_both_rdata", rdata0, 8'h55);
    chk("empty_both_count0", count0, 0);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("udf_clr", udf0, 0);

    // Simultaneous winc+rinc at count 8
    winc0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata0 = 8'h40 + 8'(i);
      tick();
    end
    wdata0 = 8'h48;
    rinc0  = 1'b1;
    tick();
    winc0 = 1'b0;
    chk("mid_both_count", count0, 8);
    chk("mid_both_rdata", rdata0, 8'h40);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("mid_both_order", rdata0, 8'h40 + i);
    end
    rinc0 = 1'b0;
    chk("mid_both_empty", rempty0, 1);

    // Error priority: set wins over clr_err
    rinc0 = 1'b1;
    tick();
    chk("udf_single", udf0, 1);
    clr0 = 1'b1;
    tick();
    rinc0 = 1'b0;
    chk("udf_set_wins", udf0, 1);
    tick();
    clr0 = 1'b0;
    chk("udf_cleared", udf0, 0);

    // Wrap-around streaming at occupancy 1..2
    nw = 0;
    nr = 0;
    occ = 0;
    cyc = 0;
    while (nr < 40 && cyc < 300) begin
      w = (nw < 40) && (occ == 0 || cyc[0]);
      r = (occ >= 1) && (occ == 2 || !cyc[0] || nw == 40);
      winc0  = w;
      rinc0  = r;
      wdata0 = 8'(nw * 7 + 3);
      tick();
      if (r) begin
        exp_d = q.pop_front();
        nr++;
        chk("wrap_rdata", rdata0, exp_d);
      end
      if (w) begin
        q.push_back(8'(nw * 7 + 3));
        nw++;
      end
      occ = q.size();
      chk("wrap_count", count0, occ);
      chk("wrap_aempty", aempty0, (occ <= 2));
      cyc++;
    end
    winc0 = 1'b0;
    rinc0 = 1'b0;
    chk("wrap_done", nr, 40);

    // FWFT: head word visible without rinc
    wdata1 = 8'hA5;
    winc1  = 1'b1;
    tick();
    wdata1 = 8'h3C;
    tick();
    winc1 = 1'b0;
    chk("fwft_rempty", rempty1, 0);
    chk("fwft_head", rdata1, 8'hA5);
    tick();
    chk("fwft_hold", rdata1, 8'hA5);
    rinc1 = 1'b1;
    tick();
    chk("fwft_next", rdata1, 8'h3C);
    chk("fwft_count1", count1, 1);
    tick();
    rinc1 = 1'b0;
    chk("fwft_empty", rempty1, 1);

    // Async reset mid-burst at count 9, with underflow previously set
    rinc0 = 1'b1;
    tick();
    rinc0 = 1'b0;
    chk("pre_rst_udf", udf0, 1);
    winc0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata0 = 8'h90 + 8'(i);
      tick();
    end
    chk("pre_rst_count", count0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count0, 0);
    chk("arst_rempty", rempty0, 1);
    chk("arst_aempty", aempty0, 1);
    chk("arst_wfull", wfull0, 0);
    chk("arst_afull", afull0, 0);
    chk("arst_udf", udf0, 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_rdata", rdata0, 0);
    winc0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
